// File: rtl/block_word_reader_416.sv
// block_word_reader_416
//   Read side of the 416-bit SHA-2 block save register. A start request in
//   IDLE captures block_in into a private shift register; the words are then
//   streamed most-significant first with valid/ready flow control.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   start      capture block_in and begin streaming (IDLE only)
//   abort      synchronous flush back to IDLE, no done pulse
//   block_in   stored block, word 0 in the top WORD_W bits
//   out_word   current word (zero while not valid)
//   out_valid  out_word is valid
//   out_ready  consumer accepts out_word this cycle
//   out_last   current word is word NUM_WORDS-1
//   word_idx   index of current word
//   busy       high while streaming
//   done       one-cycle pulse after the final word is accepted
//
// Build option
//   BLOCK_READER_BYTE_SWAP_EN : byte-reverse every output word
//                               (WORD_W must be a multiple of 8).
//
// state   | meaning
// S_IDLE  | waiting for start, outputs quiet
// S_STREAM| presenting top word of shift register, shift on handshake

module block_word_reader_416 #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 13,
  parameter int CNT_W     = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic                        abort,
  input  logic [WORD_W*NUM_WORDS-1:0] block_in,
  output logic [WORD_W-1:0]           out_word,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [CNT_W-1:0]            word_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int BLK_W = WORD_W * NUM_WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;

  logic               streaming;
  logic [WORD_W-1:0]  top_word;
  logic [WORD_W-1:0]  word_fmt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          shreg_d = block_in;
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // abort wins over a same-cycle handshake: the word is dropped
        if (abort) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (out_ready) begin
          shreg_d = {shreg_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
          if (idx_q == LAST_IDX) begin
            // counter parks at 0 instead of stepping past the last index
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign streaming = (state_q == S_STREAM);
  assign top_word  = shreg_q[BLK_W-1 -: WORD_W];

`ifdef BLOCK_READER_BYTE_SWAP_EN
  for (genvar b = 0; b < WORD_W / 8; b++) begin : g_swap
    assign word_fmt[8*b +: 8] = top_word[WORD_W-8*(b+1) +: 8];
  end
`else
  assign word_fmt = top_word;
`endif

  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_word  = streaming ? word_fmt : '0;
  assign out_last  = streaming && (idx_q == LAST_IDX);
  assign word_idx  = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_block_word_reader_416.sv
module tb_block_word_reader_416;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 13;
  localparam int CNT_W     = 4;
  localparam int BLK_W     = WORD_W * NUM_WORDS;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [BLK_W-1:0]   block_in = '0;
  logic [WORD_W-1:0]  out_word;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out_last;
  logic [CNT_W-1:0]   word_idx;
  logic               busy;
  logic               done;

  block_word_reader_416 #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .block_in(block_in),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .word_idx(word_idx), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WORD_W-1:0] word;
    int                idx;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random

  function automatic logic [WORD_W-1:0] fmt(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
`ifdef BLOCK_READER_BYTE_SWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) r[8*b +: 8] = w[WORD_W-8*(b+1) +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // expected stream for a captured block: word k is the k-th word from the top
  task automatic push_block(input logic [BLK_W-1:0] blk);
    exp_t e;
    for (int k = 0; k < NUM_WORDS; k++) begin
      e.word = fmt(blk[(NUM_WORDS-1-k)*WORD_W +: WORD_W]);
      e.idx  = k;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit m_busy = 0;
  bit exp_done = 0;

  initial begin
    bit   nxt_done;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        check("reset_outputs",
              {out_valid, busy, done, out_last, 4'(word_idx), out_word},
              64'd0);
        exp_q.delete();
        m_busy   = 0;
        exp_done = 0;
      end else begin
        check("done", done, exp_done);
        check("out_valid", out_valid, m_busy);
        check("busy", busy, m_busy);
        nxt_done = 0;
        if (m_busy) begin
          if (exp_q.size() == 0) begin
            check("queue_nonempty", 0, 1);
            m_busy = 0;
          end else begin
            e = exp_q[0];
            check("out_word", out_word, e.word);
            check("word_idx", word_idx, e.idx);
            check("out_last", out_last, (e.idx == NUM_WORDS - 1));
            if (abort) begin
              exp_q.delete();
              m_busy = 0;
            end else if (out_ready) begin
              void'(exp_q.pop_front());
              if (e.idx == NUM_WORDS - 1) begin
                m_busy   = 0;
                nxt_done = 1;
              end
            end
          end
        end else if (start && !abort) begin
          m_busy = 1;
        end
        exp_done = nxt_done;
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    int pcnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (pcnt % 4 == 0) || (pcnt % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pcnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [BLK_W-1:0] blk, input bit honoured);
    if (honoured) push_block(blk);
    block_in = blk;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (!busy) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic wait_idx(input int target);
    for (int i = 0; i < 400; i++) begin
      if (out_valid && word_idx == CNT_W'(target)) return;
      cyc();
    end
    check("idx_timeout", 0, 1);
  endtask

  function automatic logic [BLK_W-1:0] rand_block();
    logic [BLK_W-1:0] b;
    for (int k = 0; k < NUM_WORDS; k++) b[k*WORD_W +: WORD_W] = $urandom;
    return b;
  endfunction

  initial begin
    logic [BLK_W-1:0] blk;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    cyc();
    cyc();

    // full rate, word k = k
    ready_mode = 0;
    for (int k = 0; k < NUM_WORDS; k++) blk[(NUM_WORDS-1-k)*WORD_W +: WORD_W] = WORD_W'(k);
    do_start(blk, 1);
    wait_idle();
    cyc();

    // byte-order check block: word0 = 0x11223344
    blk = rand_block();
    blk[BLK_W-1 -: WORD_W] = 32'h1122_3344;
    do_start(blk, 1);
    wait_idle();

    // backpressure 1,0,0,1
    ready_mode = 1;
    do_start(rand_block(), 1);
    wait_idle();

    // start ignored while busy, block_in change isolated
    ready_mode = 0;
    do_start(rand_block(), 1);
    wait_idx(4);
    block_in = '1;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    wait_idle();
    cyc();

    // abort at word 7 with ready high, then restart
    do_start(rand_block(), 1);
    wait_idx(7);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
    cyc();
    do_start(rand_block(), 1);
    wait_idle();

    // abort beats start in IDLE
    block_in = rand_block();
    start    = 1'b1;
    abort    = 1'b1;
    cyc();
    start    = 1'b0;
    abort    = 1'b0;
    cyc();

    // reset mid-stream after 5 words, then a fresh stream from word 0
    do_start(rand_block(), 1);
    wait_idx(5);
    RST = 1'b0;
    cyc();
    RST = 1'b1;
    cyc();
    do_start(rand_block(), 1);
    wait_idle();

    // randomized traffic, back-to-back starts in the done cycle included
    for (int n = 0; n < 10; n++) begin
      ready_mode = int'($urandom_range(0, 2));
      do_start(rand_block(), 1);
      wait_idle();
      if ($urandom_range(0, 1) == 1) cyc();
    end

    ready_mode = 0;
    repeat (3) cyc();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_word_reader_416.md
Name: block_word_reader_416

Overview:
- Read-side companion to the 416-bit block save register in the SHA-2 datapath.
- On a start request it captures the stored 416-bit block (13 x 32-bit words).
- It then streams the words one per handshake, most-significant word first, to the message-schedule / W-word consumer.
- It provides valid/ready flow control, a last-word flag, busy status and a done pulse.

Parameters:
- WORD_W, 32, width of each output word in bits.
- NUM_WORDS, 13, words per block; block width is WORD_W*NUM_WORDS (416 by default).
- CNT_W, 4, width of the word counter; must satisfy 2^CNT_W >= NUM_WORDS.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- start  input  1  request to capture block_in and begin streaming; honoured only in IDLE.
- abort  input  1  synchronous flush; returns to IDLE without done.
- block_in  input  WORD_W*NUM_WORDS  stored block from the block save register.
- out_word  output  WORD_W  current word.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  consumer accepts out_word this cycle.
- out_last  output  1  current word is word NUM_WORDS-1.
- word_idx  output  CNT_W  index of current word (0..NUM_WORDS-1).
- busy  output  1  high while in STREAM.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous, active-low.
- Reset (RST=0, at any time including mid-stream):
  - state=IDLE.
  - Shift register, word counter, out_word, word_idx all = 0.
  - out_valid, out_last, busy, done all = 0.
- States are IDLE and STREAM.
- IDLE:
  - out_valid=0, busy=0.
  - If start=1 and abort=0: latch block_in into the internal shift register, word_idx=0, go to STREAM.
  - out_valid=1 in the cycle after start (latency 1).
- STREAM:
  - out_word = shift-register bits [top WORD_W-1 : 0 of the top slice].
  - Word k = block_in[WORD_W*(NUM_WORDS-k)-1 : WORD_W*(NUM_WORDS-k-1)]; word 0 is block_in[415:384].
  - out_last = (word_idx == NUM_WORDS-1).
- Transfer: out_valid & out_ready in a cycle.
  - On transfer: shift left by WORD_W, word_idx+1.
  - If out_last: go to IDLE and assert done for exactly the next cycle.
- Stall: while out_valid=1 and out_ready=0, out_word, out_last and word_idx hold stable.
- Throughput: with out_ready held high, 13 words in 13 consecutive cycles, then done in cycle 14 after start+1.
- start while busy (including the cycle of the final transfer): ignored; no re-capture and no queueing.
- block_in changing after capture has no effect on the stream in progress.
- abort=1:
  - In STREAM: next state IDLE, out_valid=0, done stays 0; a transfer in the same cycle is discarded.
  - In IDLE: has priority over start.
- done and out_valid are never high in the same cycle.
- Counter never exceeds NUM_WORDS-1; no wrap-around occurs.

Optional Feature:
- Macro: BLOCK_READER_BYTE_SWAP_EN.
- Defined: each out_word is byte-reversed before output, i.e. byte0<->byte3 and byte1<->byte2 for WORD_W=32. Used for little-endian header fields. WORD_W must be a multiple of 8.
- Undefined: words are output unmodified. No other behaviour differs.

Test Plan:
- Reset mid-stream: start, accept 5 words, assert RST=0 for 1 cycle -> all outputs 0, state IDLE. Next start streams from word 0.
- Full-rate stream: block_in words = 0x00000000..0x0000000C (word0 = 0x00000000 in bits [415:384]), start for 1 cycle, out_ready=1 -> out_word 0x0..0xC on 13 consecutive cycles. out_last only with 0xC. done pulse 1 cycle later. busy low after.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly -> each word held stable while not ready. No word duplicated or skipped; word_idx monotonic 0..12.
- Ignored start / capture isolation: start again at word 4 and change block_in to all 0xFFFFFFFF -> stream continues with original words 4..12, single done.
- Abort: abort at word_idx=7 with out_ready=1 -> word 7 discarded, out_valid=0 next cycle, done never asserted. A new start streams from word 0.
- Byte swap (macro defined): word0 = 0x11223344 -> out_word 0x44332211. Macro undefined -> out_word 0x11223344.
